burst_ram_arbiter: RTL and testbench

- Shares one BurstRAM command/data interface between two cache requesters: port 0 (instruction cache) and port 1 (data cache).
- Grants are round-robin and held for the whole transaction.
- After a requester releases, the arbiter drains in-flight read beats and waits for `br_busy` to fall before granting again.
- Sits between the cache pair and the BurstRAM controller.

---
 rtl/burst_ram_arbiter_pkg.sv | 18 +
 rtl/burst_ram_arbiter_beat.sv | 73 +++++++
 rtl/burst_ram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_burst_ram_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_ram_arbiter_pkg.sv
// Shared encodings for the two-port BurstRAM arbiter: one-hot FSM states,
// requester port indices and BurstRAM command codes.
package burst_ram_arbiter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_GRANT0 = 4'b0010,
    ST_GRANT1 = 4'b0100,
    ST_DRAIN  = 4'b1000
  } arb_state_e;

  localparam logic PORT_ICACHE  = 1'b0;
  localparam logic PORT_DCACHE  = 1'b1;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter_beat.sv
// burst_beat_tracker: counts read beats still owed by the BurstRAM and routes
// each returning beat to the port that issued the oldest outstanding read.
module burst_beat_tracker
  import burst_ram_arbiter_pkg::*;
#(
  parameter  int BURST_COUNT = 4,
  localparam int CNT_W       = $clog2(2 * BURST_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_fire,
  input  logic             cmd,
  input  logic             cmd_port,
  input  logic             beat_valid,
  output logic             beat_valid_p0,
  output logic             beat_valid_p1,
  output logic [CNT_W-1:0] outstanding
);

  localparam int BEAT_W = $clog2(BURST_COUNT + 1);

  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic [BEAT_W-1:0] beat_idx_q, beat_idx_d;
  logic [1:0]        owner_q, owner_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              read_issue, beat_take, burst_done;

  assign read_issue = cmd_fire && (cmd != BR_CMD_WRITE);
  // Beats arriving with nothing owed are stray and must not wrap the counter.
  assign beat_take  = beat_valid && (out_cnt_q != '0);
  assign burst_done = beat_take && (beat_idx_q == BEAT_W'(BURST_COUNT - 1));

  always_comb begin
    out_cnt_d = out_cnt_q;
    if (read_issue) out_cnt_d = out_cnt_d + CNT_W'(BURST_COUNT);
    if (beat_take)  out_cnt_d = out_cnt_d - CNT_W'(1);
    beat_idx_d = beat_idx_q;
    if (burst_done)     beat_idx_d = '0;
    else if (beat_take) beat_idx_d = beat_idx_q + BEAT_W'(1);
    rd_ptr_d = rd_ptr_q ^ burst_done;
    wr_ptr_d = wr_ptr_q ^ read_issue;
    owner_d  = owner_q;
    if (read_issue) owner_d[wr_ptr_q] = cmd_port;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt_q  <= '0;
      beat_idx_q <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      out_cnt_q  <= out_cnt_d;
      beat_idx_q <= beat_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
    owner_q <= owner_d;
  end

  assign beat_valid_p0 = !rst && beat_take && (owner_q[rd_ptr_q] == PORT_ICACHE);
  assign beat_valid_p1 = !rst && beat_take && (owner_q[rd_ptr_q] == PORT_DCACHE);
  assign outstanding   = out_cnt_q;

`ifdef DBG
  always @(posedge clk) begin
    if (!rst && beat_valid && out_cnt_q == '0)
      $display("burst_beat_tracker: read beat with no outstanding read");
  end
`endif

endmodule

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM between the I-cache (port 0) and
// D-cache (port 1). Define BURST_ARB_STATS_EN to add grant/contention counters.
module burst_ram_arbiter
  import burst_ram_arbiter_pkg::*;
#(
  parameter int RAM_DEPTH_BITWIDTH      = 4,
  parameter int RAM_BURST_DATA_COUNT    = 4,
  parameter int RAM_BURST_DATA_BITWIDTH = 64,
  parameter int STATS_BITWIDTH          = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 p0_req,
  output logic                                 p0_gnt,
  input  logic                                 p0_cmd,
  input  logic                                 p0_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p0_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p0_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p0_data_mask,
  output logic                                 p0_rd_data_valid,
  output logic                                 p0_busy,
  input  logic                                 p1_req,
  output logic                                 p1_gnt,
  input  logic                                 p1_cmd,
  input  logic                                 p1_cmd_en,
  input  logic [RAM_DEPTH_BITWIDTH-1:0]        p1_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   p1_wr_data,
  input  logic [RAM_BURST_DATA_BITWIDTH/8-1:0] p1_data_mask,
  output logic                                 p1_rd_data_valid,
  output logic                                 p1_busy,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   rd_data,
  output logic                                 br_cmd,
  output logic                                 br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
  output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
  output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
  input  logic                                 br_rd_data_valid,
  input  logic                                 br_busy
`ifdef BURST_ARB_STATS_EN
  ,
  output logic [STATS_BITWIDTH-1:0]            stat_grants0,
  output logic [STATS_BITWIDTH-1:0]            stat_grants1,
  output logic [STATS_BITWIDTH-1:0]            stat_contention
`endif
);

  localparam int CNT_W = $clog2(2 * RAM_BURST_DATA_COUNT + 1);

  arb_state_e       state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] outstanding;

  // Arbitration only happens from IDLE, so a release always costs DRAIN + IDLE.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (p0_req && (!p1_req || last_q == PORT_DCACHE)) state_d = ST_GRANT0;
        else if (p1_req)                                  state_d = ST_GRANT1;
      end
      ST_GRANT0: if (!p0_req) begin
        state_d = ST_DRAIN;
        last_d  = PORT_ICACHE;
      end
      ST_GRANT1: if (!p1_req) begin
        state_d = ST_DRAIN;
        last_d  = PORT_DCACHE;
      end
      ST_DRAIN: if (outstanding == '0 && !br_busy) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    gnt0_d = (state_d == ST_GRANT0);
    gnt1_d = (state_d == ST_GRANT1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      last_q  <= PORT_DCACHE;
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      last_q  <= last_d;
    end
  end

  assign p0_gnt = gnt0_q;
  assign p1_gnt = gnt1_q;

  always_comb begin
    br_cmd       = BR_CMD_READ;
    br_cmd_en    = 1'b0;
    br_addr      = '0;
    br_wr_data   = '0;
    br_data_mask = '0;
    p0_busy      = 1'b1;
    p1_busy      = 1'b1;
    if (!rst) begin
      if (state_q == ST_GRANT0) begin
        br_cmd       = p0_cmd;
        br_cmd_en    = p0_cmd_en;
        br_addr      = p0_addr;
        br_wr_data   = p0_wr_data;
        br_data_mask = p0_data_mask;
        p0_busy      = br_busy;
      end else if (state_q == ST_GRANT1) begin
        br_cmd       = p1_cmd;
        br_cmd_en    = p1_cmd_en;
        br_addr      = p1_addr;
        br_wr_data   = p1_wr_data;
        br_data_mask = p1_data_mask;
        p1_busy      = br_busy;
      end
    end
  end

  assign rd_data = br_rd_data;

  burst_beat_tracker #(
    .BURST_COUNT (RAM_BURST_DATA_COUNT)
  ) u_tracker (
    .clk           (clk),
    .rst           (rst),
    .cmd_fire      (br_cmd_en),
    .cmd           (br_cmd),
    .cmd_port      ((state_q == ST_GRANT1) ? PORT_DCACHE : PORT_ICACHE),
    .beat_valid    (br_rd_data_valid),
    .beat_valid_p0 (p0_rd_data_valid),
    .beat_valid_p1 (p1_rd_data_valid),
    .outstanding   (outstanding)
  );

`ifdef BURST_ARB_STATS_EN
  logic [STATS_BITWIDTH-1:0] grants0_q, grants0_d;
  logic [STATS_BITWIDTH-1:0] grants1_q, grants1_d;
  logic [STATS_BITWIDTH-1:0] contention_q, contention_d;

  function automatic logic [STATS_BITWIDTH-1:0] sat_inc(
    input logic [STATS_BITWIDTH-1:0] v,
    input logic                      en
  );
    return (en && v != '1) ? v + STATS_BITWIDTH'(1) : v;
  endfunction

  always_comb begin
    grants0_d    = sat_inc(grants0_q, state_q == ST_IDLE && state_d == ST_GRANT0);
    grants1_d    = sat_inc(grants1_q, state_q == ST_IDLE && state_d == ST_GRANT1);
    contention_d = sat_inc(contention_q, state_q == ST_IDLE && p0_req && p1_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grants0_q    <= '0;
      grants1_q    <= '0;
      contention_q <= '0;
    end else begin
      grants0_q    <= grants0_d;
      grants1_q    <= grants1_d;
      contention_q <= contention_d;
    end
  end

  assign stat_grants0    = grants0_q;
  assign stat_grants1    = grants1_q;
  assign stat_contention = contention_q;
`else
  logic unused_stats_cfg;
  assign unused_stats_cfg = (STATS_BITWIDTH > 0);
`endif

`ifdef DBG
  always @(posedge clk) begin
    if (!rst && p0_cmd_en && state_q != ST_GRANT0)
      $display("burst_ram_arbiter: cmd_en from ungranted port 0 dropped");
    if (!rst && p1_cmd_en && state_q != ST_GRANT1)
      $display("burst_ram_arbiter: cmd_en from ungranted port 1 dropped");
  end
`endif

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Bench for burst_ram_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_burst_ram_arbiter;

  localparam int AW = 4;
  localparam int BC = 4;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst;
  logic p0_req, p0_gnt, p0_cmd, p0_cmd_en, p0_rd_data_valid, p0_busy;
  logic p1_req, p1_gnt, p1_cmd, p1_cmd_en, p1_rd_data_valid, p1_busy;
  logic [AW-1:0] p0_addr, p1_addr, br_addr;
  logic [DW-1:0] p0_wr_data, p1_wr_data, br_wr_data, rd_data, br_rd_data;
  logic [MW-1:0] p0_data_mask, p1_data_mask, br_data_mask;
  logic br_cmd, br_cmd_en, br_rd_data_valid, br_busy;
`ifdef BURST_ARB_STATS_EN
  logic [SW-1:0] stat_grants0, stat_grants1, stat_contention;
`endif

  always #5 clk = ~clk;

  burst_ram_arbiter #(
    .RAM_DEPTH_BITWIDTH      (AW),
    .RAM_BURST_DATA_COUNT    (BC),
    .RAM_BURST_DATA_BITWIDTH (DW),
    .STATS_BITWIDTH          (SW)
  ) dut (
    .clk (clk), .rst (rst),
    .p0_req (p0_req), .p0_gnt (p0_gnt), .p0_cmd (p0_cmd), .p0_cmd_en (p0_cmd_en),
    .p0_addr (p0_addr), .p0_wr_data (p0_wr_data), .p0_data_mask (p0_data_mask),
    .p0_rd_data_valid (p0_rd_data_valid), .p0_busy (p0_busy),
    .p1_req (p1_req), .p1_gnt (p1_gnt), .p1_cmd (p1_cmd), .p1_cmd_en (p1_cmd_en),
    .p1_addr (p1_addr), .p1_wr_data (p1_wr_data), .p1_data_mask (p1_data_mask),
    .p1_rd_data_valid (p1_rd_data_valid), .p1_busy (p1_busy),
    .rd_data (rd_data), .br_cmd (br_cmd), .br_cmd_en (br_cmd_en), .br_addr (br_addr),
    .br_wr_data (br_wr_data), .br_data_mask (br_data_mask), .br_rd_data (br_rd_data),
    .br_rd_data_valid (br_rd_data_valid), .br_busy (br_busy)
`ifdef BURST_ARB_STATS_EN
    , .stat_grants0 (stat_grants0), .stat_grants1 (stat_grants1),
    .stat_contention (stat_contention)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: who holds the RAM, whether a release is still draining,
  // and one queue entry per read beat still owed, tagged with its owner.
  int m_holder = -1;
  bit m_drain  = 1'b0;
  int m_last   = 1;
  int m_q[$];
  int m_g0 = 0, m_g1 = 0, m_ct = 0;
  int ram_pend = 0;
  int rdv0_cnt = 0, rdv1_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic f_req(input int n);
    return (n == 0) ? p0_req : p1_req;
  endfunction
  function automatic logic f_cmd_en(input int n);
    return (n == 0) ? p0_cmd_en : p1_cmd_en;
  endfunction
  function automatic logic f_cmd(input int n);
    return (n == 0) ? p0_cmd : p1_cmd;
  endfunction
  function automatic logic [AW-1:0] f_addr(input int n);
    return (n == 0) ? p0_addr : p1_addr;
  endfunction
  function automatic logic [DW-1:0] f_wd(input int n);
    return (n == 0) ? p0_wr_data : p1_wr_data;
  endfunction
  function automatic logic [MW-1:0] f_mask(input int n);
    return (n == 0) ? p0_data_mask : p1_data_mask;
  endfunction

  // Called at a negedge with this cycle's inputs applied: compare, then advance
  // the model across the coming posedge, and return at the next negedge.
  task automatic step();
    logic exp_en, fwd_read, beat0, beat1;
    int pre_size;
    #1;
    exp_en = !rst && (m_holder >= 0) && f_cmd_en(m_holder);
    beat0  = !rst && br_rd_data_valid && (m_q.size() > 0) && (m_q[0] == 0);
    beat1  = !rst && br_rd_data_valid && (m_q.size() > 0) && (m_q[0] == 1);
    chk("p0_gnt", p0_gnt, m_holder == 0);
    chk("p1_gnt", p1_gnt, m_holder == 1);
    chk("p0_busy", p0_busy, (!rst && m_holder == 0) ? br_busy : 1'b1);
    chk("p1_busy", p1_busy, (!rst && m_holder == 1) ? br_busy : 1'b1);
    chk("br_cmd_en", br_cmd_en, exp_en);
    if (exp_en) begin
      chk("br_cmd", br_cmd, f_cmd(m_holder));
      chk("br_addr", br_addr, f_addr(m_holder));
      chk("br_wr_data", br_wr_data, f_wd(m_holder));
      chk("br_data_mask", br_data_mask, f_mask(m_holder));
    end
    chk("rd_data", rd_data, br_rd_data);
    chk("p0_rd_data_valid", p0_rd_data_valid, beat0);
    chk("p1_rd_data_valid", p1_rd_data_valid, beat1);
    if (p0_rd_data_valid) rdv0_cnt++;
    if (p1_rd_data_valid) rdv1_cnt++;
`ifdef BURST_ARB_STATS_EN
    chk("stat_grants0", stat_grants0, m_g0);
    chk("stat_grants1", stat_grants1, m_g1);
    chk("stat_contention", stat_contention, m_ct);
`endif
    pre_size = m_q.size();
    fwd_read = exp_en && (f_cmd(m_holder) == 1'b0);
    if (br_rd_data_valid && ram_pend > 0) ram_pend--;
    if (fwd_read) ram_pend += BC;
    if (rst) begin
      m_holder = -1; m_drain = 1'b0; m_last = 1;
      m_q.delete();
      m_g0 = 0; m_g1 = 0; m_ct = 0;
    end else begin
      if (br_rd_data_valid && pre_size > 0) void'(m_q.pop_front());
      if (fwd_read) repeat (BC) m_q.push_back(m_holder);
      if (m_holder >= 0) begin
        if (!f_req(m_holder)) begin
          m_last = m_holder; m_holder = -1; m_drain = 1'b1;
        end
      end else if (m_drain) begin
        if (pre_size == 0 && !br_busy) m_drain = 1'b0;
      end else begin
        if (p0_req && p1_req) begin
          m_holder = 1 - m_last;
          if (m_ct < 65535) m_ct++;
        end else if (p0_req) m_holder = 0;
        else if (p1_req) m_holder = 1;
        if (m_holder == 0 && m_g0 < 65535) m_g0++;
        if (m_holder == 1 && m_g1 < 65535) m_g1++;
      end
    end
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rst = 1'b0; br_rd_data = '0; br_rd_data_valid = 1'b0; br_busy = 1'b0;
    p0_req = 1'b0; p0_cmd = 1'b0; p0_cmd_en = 1'b0; p0_addr = '0; p0_wr_data = '0; p0_data_mask = '0;
    p1_req = 1'b0; p1_cmd = 1'b0; p1_cmd_en = 1'b0; p1_addr = '0; p1_wr_data = '0; p1_data_mask = '0;
  endtask

  task automatic wait_gnt(input int n, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (((n == 0) ? p0_gnt : p1_gnt) === 1'b1) got = 1'b1;
    end
    chk(name, got, 1'b1);
  endtask

  task automatic beats(input int n);
    for (int i = 0; i < n; i++) begin
      br_rd_data = {$urandom, $urandom};
      br_rd_data_valid = 1'b1;
      step();
      br_rd_data_valid = 1'b0;
      step();
    end
  endtask

  task automatic rand_port(input int n, input logic cur_req, output logic req, output logic cmd,
                           output logic cmd_en, output logic [AW-1:0] addr,
                           output logic [DW-1:0] wd, output logic [MW-1:0] mask);
    req    = cur_req;
    cmd    = 1'($urandom_range(0, 1));
    cmd_en = 1'b0;
    addr   = AW'($urandom);
    wd     = {$urandom, $urandom};
    mask   = MW'($urandom);
    if (m_holder == n) begin
      if ($urandom_range(0, 5) == 0) req = 1'b0;
      if (!br_busy && $urandom_range(0, 1) == 1) begin
        cmd_en = 1'b1;
        if (cmd == 1'b0 && m_q.size() > BC) cmd = 1'b1;
      end
    end else begin
      if (!cur_req && $urandom_range(0, 3) == 0) req = 1'b1;
      cmd_en = ($urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    step();
    chk("reset_p0_gnt", p0_gnt, 1'b0);
    chk("reset_p1_gnt", p1_gnt, 1'b0);
    chk("reset_p0_busy", p0_busy, 1'b1);
    chk("reset_br_cmd_en", br_cmd_en, 1'b0);

    // Lone port-0 request, one read burst at address 5.
    rst = 1'b0; p0_req = 1'b1;
    step();
    chk("single_p0_gnt", p0_gnt, 1'b1);
    chk("single_p1_gnt", p1_gnt, 1'b0);
    p0_cmd_en = 1'b1; p0_cmd = 1'b0; p0_addr = 4'd5;
    #1;
    chk("single_br_cmd_en", br_cmd_en, 1'b1);
    chk("single_br_addr", br_addr, 4'd5);
    step();
    p0_cmd_en = 1'b0;
    rdv0_cnt = 0; rdv1_cnt = 0;
    beats(4);
    chk("single_p0_beats", rdv0_cnt, 4);
    chk("single_p1_beats", rdv1_cnt, 0);
    p0_req = 1'b0;
    repeat (3) step();

    // Tie out of reset goes to port 0, then round-robin to port 1, then back.
    rst = 1'b1; p0_req = 1'b1; p1_req = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("tie_first_p0", p0_gnt, 1'b1);
    chk("tie_first_p1", p1_gnt, 1'b0);
    p0_req = 1'b0;
    wait_gnt(1, "tie_second_p1");
    p1_req = 1'b0;
    step();
    p0_req = 1'b1; p1_req = 1'b1;
    wait_gnt(0, "tie_third_p0");
    chk("tie_third_p1_low", p1_gnt, 1'b0);

    // Ungranted port-0 strobes while port 1 owns the RAM.
    p0_req = 1'b0;
    wait_gnt(1, "ungranted_setup");
    p0_req = 1'b1; p0_cmd_en = 1'b1; p0_addr = 4'd9;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ungranted_br_cmd_en", br_cmd_en, 1'b0);
      chk("ungranted_p0_busy", p0_busy, 1'b1);
      step();
    end
    p0_cmd_en = 1'b0;

    // Port 0 reads then releases; port 1 waits for all beats and br_busy low.
    p1_req = 1'b0;
    wait_gnt(0, "drain_setup");
    p1_req = 1'b1;
    p0_cmd_en = 1'b1; p0_cmd = 1'b0; p0_addr = 4'd3;
    step();
    p0_cmd_en = 1'b0; p0_req = 1'b0; br_busy = 1'b1;
    step();
    rdv0_cnt = 0; rdv1_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      br_rd_data = {$urandom, $urandom};
      br_rd_data_valid = (i % 2 == 1);
      step();
      chk("drain_p1_held_off", p1_gnt, 1'b0);
    end
    br_rd_data_valid = 1'b0; br_busy = 1'b0;
    wait_gnt(1, "drain_then_p1");
    chk("drain_p0_beats", rdv0_cnt, 4);
    chk("drain_p1_beats", rdv1_cnt, 0);

    // Reset after two beats of a burst: grants drop, later beats go nowhere.
    p1_req = 1'b0; p0_req = 1'b1;
    wait_gnt(0, "rst_setup");
    p0_cmd_en = 1'b1; p0_cmd = 1'b0;
    step();
    p0_cmd_en = 1'b0;
    rdv0_cnt = 0; rdv1_cnt = 0;
    beats(2);
    rst = 1'b1; p0_req = 1'b0; br_rd_data_valid = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_p0_gnt", p0_gnt, 1'b0);
    chk("rst_mid_p1_gnt", p1_gnt, 1'b0);
    chk("rst_mid_counter", dut.u_tracker.out_cnt_q, 0);
    step();
    br_rd_data_valid = 1'b0;
    step();
    chk("rst_mid_beats_routed", rdv0_cnt + rdv1_cnt, 2);

    // A fresh burst after stray beats still routes exactly four beats.
    p0_req = 1'b1;
    wait_gnt(0, "fresh_setup");
    p0_cmd_en = 1'b1; p0_cmd = 1'b0;
    step();
    p0_cmd_en = 1'b0;
    rdv0_cnt = 0;
    beats(4);
    chk("fresh_p0_beats", rdv0_cnt, 4);
    p0_req = 1'b0;
    repeat (3) step();

    // Randomized traffic with a reactive BurstRAM model.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 599) == 0);
      br_rd_data = {$urandom, $urandom};
      br_rd_data_valid = (ram_pend > 0) && ($urandom_range(0, 2) != 0);
      br_busy = ($urandom_range(0, 3) == 0) || (ram_pend > 0 && $urandom_range(0, 1) == 0);
      rand_port(0, p0_req, p0_req, p0_cmd, p0_cmd_en, p0_addr, p0_wr_data, p0_data_mask);
      rand_port(1, p1_req, p1_req, p1_cmd, p1_cmd_en, p1_addr, p1_wr_data, p1_data_mask);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
